// File: rtl/uc_atende_fila_if.sv
// Queue-head link between the request queue and the service FSM.
// The FSM side (master) issues pop; the queue side (slave) presents the head entry.
interface uc_atende_fila_if #(
  parameter int ANDAR_W = 3
);
  logic               fila_vazia;
  logic [ANDAR_W-1:0] fila_andar;
  logic               pop;

  modport master (input fila_vazia, input fila_andar, output pop);
  modport slave  (output fila_vazia, output fila_andar, input pop);
endinterface

// File: rtl/uc_atende_fila.sv
// Serves the head of the request queue: moves the cab one floor per step,
// opens the door on arrival and pops the entry; the head is re-read after every step.
//
// state      | meaning
// IDLE       | queue empty, cab parked
// LE_DESTINO | latch head floor into destino
// COMPARA    | choose up / down / door / discard
// SOBE       | one-floor move up, T_ANDAR cycles
// DESCE      | one-floor move down, T_ANDAR cycles
// PORTA      | door open, T_PORTA cycles
// REMOVE     | pop the served entry
// ESPERA     | settle cycle while the queue updates its head
// DESCARTA   | pop an out-of-range entry and flag it
module uc_atende_fila #(
  parameter int N_ANDARES = 8,
  parameter int ANDAR_W   = 3,
  parameter int T_ANDAR   = 50,
  parameter int T_PORTA   = 100,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  uc_atende_fila_if.master     fila,
  input  logic                 pausa,
  output logic [ANDAR_W-1:0]   andar_atual,
  output logic                 subindo,
  output logic                 descendo,
  output logic                 porta_aberta,
  output logic                 ocupado,
  output logic                 erro_destino,
  output logic [3:0]           Eatual_db
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LE_DESTINO = 4'd1,
    COMPARA    = 4'd2,
    SOBE       = 4'd3,
    DESCE      = 4'd4,
    PORTA      = 4'd5,
    REMOVE     = 4'd6,
    ESPERA     = 4'd7,
    DESCARTA   = 4'd8
  } estado_t;

  localparam logic [CNT_W-1:0] TC_ANDAR = CNT_W'(T_ANDAR - 1);
  localparam logic [CNT_W-1:0] TC_PORTA = CNT_W'(T_PORTA - 1);

  estado_t              estado, estado_nxt;
  logic [ANDAR_W-1:0]   destino, destino_nxt, andar_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;

  always_comb begin
    estado_nxt  = estado;
    destino_nxt = destino;
    andar_nxt   = andar_atual;
    cnt_nxt     = cnt;
    case (estado)
      IDLE: begin
        if (!fila.fila_vazia) estado_nxt = LE_DESTINO;
      end
      LE_DESTINO: begin
        destino_nxt = fila.fila_andar;
        cnt_nxt     = '0;
        estado_nxt  = fila.fila_vazia ? IDLE : COMPARA;
      end
      COMPARA: begin
        if (int'(destino) >= N_ANDARES)  estado_nxt = DESCARTA;
        else if (destino == andar_atual) estado_nxt = PORTA;
        else if (destino > andar_atual)  estado_nxt = SOBE;
        else                             estado_nxt = DESCE;
      end
      // Pause freezes the timed states only, so pops are never lost or repeated.
      SOBE: begin
        if (!pausa) begin
          if (cnt == TC_ANDAR) begin
            andar_nxt  = andar_atual + ANDAR_W'(1);
            cnt_nxt    = '0;
            estado_nxt = LE_DESTINO;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      DESCE: begin
        if (!pausa) begin
          if (cnt == TC_ANDAR) begin
            andar_nxt  = andar_atual - ANDAR_W'(1);
            cnt_nxt    = '0;
            estado_nxt = LE_DESTINO;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      PORTA: begin
        if (!pausa) begin
          if (cnt == TC_PORTA) begin
            cnt_nxt    = '0;
            estado_nxt = REMOVE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      REMOVE:   estado_nxt = ESPERA;
      ESPERA:   estado_nxt = IDLE;
      DESCARTA: estado_nxt = ESPERA;
      default:  estado_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they always match the current state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= IDLE;
      destino      <= '0;
      andar_atual  <= '0;
      cnt          <= '0;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
      ocupado      <= 1'b0;
      erro_destino <= 1'b0;
      fila.pop     <= 1'b0;
    end else begin
      estado       <= estado_nxt;
      destino      <= destino_nxt;
      andar_atual  <= andar_nxt;
      cnt          <= cnt_nxt;
      subindo      <= (estado_nxt == SOBE);
      descendo     <= (estado_nxt == DESCE);
      porta_aberta <= (estado_nxt == PORTA);
      ocupado      <= (estado_nxt != IDLE);
      erro_destino <= (estado_nxt == DESCARTA);
      fila.pop     <= (estado_nxt == REMOVE) || (estado_nxt == DESCARTA);
    end
  end

  assign Eatual_db = estado;

endmodule

// File: tb/tb_uc_atende_fila.sv
// Directed bench for uc_atende_fila with a small queue model feeding the head.
module tb_uc_atende_fila;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pausa = 1'b0;
  logic [AW-1:0] andar_atual, andar2;
  logic          subindo, descendo, porta_aberta, ocupado, erro_destino;
  logic          subindo2, descendo2, porta2, ocupado2, erro2;
  logic [3:0]    Eatual_db, Eatual2;

  always #5 clock = ~clock;

  uc_atende_fila_if #(.ANDAR_W(AW)) fila_if ();
  uc_atende_fila_if #(.ANDAR_W(AW)) fila2_if ();

  uc_atende_fila #(.N_ANDARES(8), .ANDAR_W(AW), .T_ANDAR(4), .T_PORTA(3), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .fila(fila_if), .pausa(pausa),
    .andar_atual(andar_atual), .subindo(subindo), .descendo(descendo),
    .porta_aberta(porta_aberta), .ocupado(ocupado), .erro_destino(erro_destino),
    .Eatual_db(Eatual_db)
  );

  uc_atende_fila #(.N_ANDARES(6), .ANDAR_W(AW), .T_ANDAR(4), .T_PORTA(3), .CNT_W(8)) dut6 (
    .clock(clock), .reset(reset), .fila(fila2_if), .pausa(pausa),
    .andar_atual(andar2), .subindo(subindo2), .descendo(descendo2),
    .porta_aberta(porta2), .ocupado(ocupado2), .erro_destino(erro2),
    .Eatual_db(Eatual2)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [AW-1:0] q[$];
  int cyc, n_sobe, n_desce, n_porta, n_pop, porta_cyc, pop_cyc, n_chg, pause_left;
  int chg_cyc[4];
  int st_pos_pop;
  logic [AW-1:0] porta_andar, andar_prev;
  bit inject = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic upd();
    fila_if.fila_vazia = (q.size() == 0);
    fila_if.fila_andar = (q.size() > 0) ? q[0] : '0;
  endtask

  task automatic clr();
    cyc = 0; n_sobe = 0; n_desce = 0; n_porta = 0; n_pop = 0;
    porta_cyc = -1; pop_cyc = -1; n_chg = 0; st_pos_pop = -1;
    porta_andar = '0; andar_prev = andar_atual;
    for (int i = 0; i < 4; i++) chg_cyc[i] = -1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (subindo) n_sobe++;
    if (descendo) n_desce++;
    if (porta_aberta) n_porta++;
    if (porta_aberta && porta_cyc < 0) begin
      porta_cyc = cyc;
      porta_andar = andar_atual;
    end
    if (pop_cyc >= 0 && cyc == pop_cyc + 1) st_pos_pop = int'(Eatual_db);
    if (fila_if.pop) begin
      n_pop++;
      pop_cyc = cyc;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (andar_atual != andar_prev) begin
      if (n_chg < 4) chg_cyc[n_chg] = cyc;
      n_chg++;
      andar_prev = andar_atual;
    end
    // Insertion ahead of the current head while the cab is climbing.
    if (inject && Eatual_db == 4'd3) begin
      q.delete();
      q.push_back(3'd2);
      q.push_back(3'd5);
      inject = 1'b0;
    end
    if (pause_left > 0 && Eatual_db == 4'd4) begin
      pausa = 1'b1;
      pause_left--;
    end else begin
      pausa = 1'b0;
    end
    upd();
  endtask

  task automatic run(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (n_pop > 0 && q.size() == 0 && Eatual_db == 4'd0) return;
    end
    chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int ne, np, ecyc, pcyc, nm;
    pause_left = 0;
    upd();
    fila2_if.fila_vazia = 1'b1;
    fila2_if.fila_andar = 3'd7;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_estado", Eatual_db, 0);
    chk("rst_andar", andar_atual, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pop", fila_if.pop, 0);
    chk("rst_porta", porta_aberta, 0);
    reset = 1'b1;

    // same floor: door only, pop on the sixth edge counting the IDLE one
    clr(); q.push_back(3'd0); upd();
    run("mesmo", 100);
    chk("mesmo_porta_n", n_porta, 3);
    chk("mesmo_porta_cyc", porta_cyc, 3);
    chk("mesmo_pop_cyc", pop_cyc, 6);
    chk("mesmo_pop_n", n_pop, 1);
    chk("mesmo_mov", n_sobe + n_desce, 0);
    chk("mesmo_andar", andar_atual, 0);

    // single upward request 0 -> 2
    clr(); q.push_back(3'd2); upd();
    run("sobe", 200);
    chk("sobe_n", n_sobe, 8);
    chk("sobe_chg0", chg_cyc[0], 7);
    chk("sobe_chg1", chg_cyc[1], 13);
    chk("sobe_andar", andar_atual, 2);
    chk("sobe_porta_cyc", porta_cyc, 15);
    chk("sobe_porta_n", n_porta, 3);
    chk("sobe_pop_cyc", pop_cyc, 18);
    chk("sobe_pop_n", n_pop, 1);
    chk("sobe_espera", st_pos_pop, 7);
    chk("sobe_idle_cyc", cyc, 20);
    chk("sobe_ocupado", ocupado, 0);

    // reset mid-move at floor 3
    reset = 1'b0; #2; reset = 1'b1;
    clr(); q.push_back(3'd5); upd();
    begin
      bit achou = 1'b0;
      for (int i = 0; i < 200 && !achou; i++) begin
        tick();
        if (andar_atual == 3'd3 && Eatual_db == 4'd3) achou = 1'b1;
      end
      chk("rst_mov_achou", achou, 1);
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_mov_andar", andar_atual, 0);
    chk("rst_mov_estado", Eatual_db, 0);
    chk("rst_mov_subindo", subindo, 0);
    chk("rst_mov_pop", fila_if.pop, 0);
    @(posedge clock); #1;
    chk("rst_mov_pop2", fila_if.pop, 0);
    q.delete(); upd();
    reset = 1'b1;

    // en-route insertion: head 5 becomes 2 while climbing from 0
    clr(); q.push_back(3'd5); inject = 1'b1; upd();
    run("carona", 400);
    chk("carona_porta_andar", porta_andar, 2);
    chk("carona_porta_cyc", porta_cyc, 15);
    chk("carona_pop_n", n_pop, 2);
    chk("carona_sobe_n", n_sobe, 20);
    chk("carona_porta_n", n_porta, 6);
    chk("carona_andar", andar_atual, 5);

    // downward move 4 -> 1 with a 10-cycle pause during DESCE
    reset = 1'b0; #2; reset = 1'b1;
    clr(); q.push_back(3'd4); upd();
    run("prep4", 300);
    chk("prep4_andar", andar_atual, 4);
    clr(); q.push_back(3'd1); pause_left = 10; upd();
    run("desce", 400);
    chk("desce_porta_cyc", porta_cyc, 31);
    chk("desce_n", n_desce, 22);
    chk("desce_andar", andar_atual, 1);
    chk("desce_pop_n", n_pop, 1);
    chk("desce_porta_n", n_porta, 3);

    // invalid head 7 with six floors
    ne = 0; np = 0; ecyc = -1; pcyc = -1; nm = 0;
    fila2_if.fila_vazia = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); #1;
      if (erro2) begin ne++; ecyc = c; end
      if (fila2_if.pop) begin np++; pcyc = c; fila2_if.fila_vazia = 1'b1; end
      if (subindo2 || descendo2 || porta2) nm++;
    end
    chk("inval_erro_n", ne, 1);
    chk("inval_pop_n", np, 1);
    chk("inval_erro_cyc", ecyc, 3);
    chk("inval_pop_cyc", pcyc, 3);
    chk("inval_mov", nm, 0);
    chk("inval_andar", andar2, 0);
    chk("inval_estado", Eatual2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uc_atende_fila.md
Name: uc_atende_fila

Overview:
- Downstream consumer of the request-queue (secondary RAM) that the new-entry control unit fills and orders.
- Reads the head entry, moves the cab one floor at a time toward it and opens the door on arrival. After the door period it pops the entry.
- Re-reads the head after every floor step, so that requests inserted en route ("carona") are served at the correct floor.
- Contains its own FSM plus the floor register, destination register and tick counter.

Parameters:
N_ANDARES, 8, number of floors; valid floors are 0..N_ANDARES-1
ANDAR_W, 3, width of floor fields; must satisfy 2^ANDAR_W >= N_ANDARES
T_ANDAR, 50, clock cycles per one-floor move
T_PORTA, 100, clock cycles the door stays open
CNT_W, 8, tick counter width; must satisfy 2^CNT_W > max(T_ANDAR, T_PORTA)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
fila_vazia  in  1  queue has no entries
fila_andar  in  ANDAR_W  floor stored at queue head; valid whenever fila_vazia=0
pausa  in  1  emergency hold; freezes counters and state
pop  out  1  one-cycle pulse; removes the head entry from the queue
andar_atual  out  ANDAR_W  current cab floor
subindo  out  1  cab moving up
descendo  out  1  cab moving down
porta_aberta  out  1  door open
ocupado  out  1  FSM is not in IDLE
erro_destino  out  1  one-cycle pulse; head floor >= N_ANDARES was discarded
Eatual_db  out  4  current state code, for debug

Behaviour:
- Reset (reset=0, async): state IDLE; andar_atual=0; destino=0; counter=0; all 1-bit outputs 0. Reset mid-move or mid-door is abandoned immediately. No pop is issued.
- States and encoding:
  - IDLE=0: if fila_vazia=0, go to LE_DESTINO; otherwise stay.
  - LE_DESTINO=1: destino <= fila_andar; counter <= 0. If fila_vazia=1, go to IDLE; otherwise go to COMPARA.
  - COMPARA=2:
    - destino >= N_ANDARES: go to DESCARTA.
    - destino == andar_atual: go to PORTA.
    - destino > andar_atual: go to SOBE.
    - Otherwise: go to DESCE.
  - SOBE=3: subindo=1; counter increments each cycle. When counter == T_ANDAR-1: andar_atual += 1, counter <= 0, go to LE_DESTINO.
  - DESCE=4: same as SOBE with descendo=1 and andar_atual -= 1.
  - PORTA=5: porta_aberta=1; counter increments each cycle. When counter == T_PORTA-1: counter <= 0, go to REMOVE.
  - REMOVE=6: pop=1 for this cycle only; go to ESPERA.
  - ESPERA=7: one settle cycle so the queue can update its head and empty flag; go to IDLE.
  - DESCARTA=8: pop=1 and erro_destino=1 for this cycle only; go to ESPERA.
  - Any other code: go to IDLE.
- All outputs are Moore outputs, decoded from the state only.
- pausa=1 in SOBE, DESCE or PORTA:
  - counter, state and andar_atual hold.
  - subindo, descendo and porta_aberta keep their values; the door stays open while paused.
- pausa=1 in any other state: has no effect, so pop is never suppressed or duplicated.
- andar_atual never wraps: SOBE is only entered when destino > andar_atual, and DESCE only when destino < andar_atual.
- A new head arriving mid-move (changed by an insertion) takes effect at the next LE_DESTINO, i.e. after the current floor step completes. A move already in progress is never reversed mid-step.
- Queue emptied externally mid-move: the current step completes, then LE_DESTINO goes to IDLE with no pop.
- Latency from a head that matches the current floor: the IDLE cycle that sees fila_vazia=0, +LE_DESTINO, +COMPARA, +T_PORTA door cycles, then pop.

Test Plan:
All scenarios use N_ANDARES=8, T_ANDAR=4, T_PORTA=3.
1. Reset: reset=0 mid-SOBE at andar 3 -> next cycle andar_atual=0, Eatual_db=0, subindo=0, no pop.
2. Single upward request: andar 0, head=2 -> subindo=1 for 2x4 cycles; andar_atual steps 0->1->2 (each step 6 cycles apart); porta_aberta high exactly 3 cycles; then one pop pulse; then ESPERA, then IDLE.
3. Same-floor request: andar 0, head=0 -> no movement; porta_aberta for 3 cycles; pop asserted 5 cycles after the IDLE cycle that sees fila_vazia=0.
4. En-route insertion: at andar 0 heading to head=5, head changes to 2 while in SOBE -> cab stops at 2; door opens; pop; the next head (5) is then served.
5. Downward move with pause: andar 4, head=1, pausa=1 for 10 cycles during DESCE -> counter and andar frozen; total descent time extends by exactly 10 cycles; andar ends at 1.
6. Invalid entry: head=7 with N_ANDARES=6 -> erro_destino and pop high for the same single cycle; no movement; FSM returns to IDLE.
